alarm_sequencer: RTL and testbench

//  Sequences the received-digit datapath: takes each UART digit + data_valid, latches it
//  for the seven-segment decoder, and drives a timed buzzer beep pattern plus a sticky

---
 rtl/alarm_sequencer_if.sv | 21 ++
 rtl/alarm_sequencer.sv | 133 +++++++++++++
 tb/tb_alarm_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_if.sv
// rtl/alarm_sequencer_if.sv - digit/ack inputs and display/alarm outputs of alarm_sequencer
interface alarm_sequencer_if;
  logic [3:0] digit;
  logic       data_valid;
  logic       ack;
  logic [3:0] disp_digit;
  logic       disp_en;
  logic       buzzer;
  logic       led;
  logic       bad_digit;

  modport master (
    output digit, data_valid, ack,
    input  disp_digit, disp_en, buzzer, led, bad_digit
  );

  modport slave (
    input  digit, data_valid, ack,
    output disp_digit, disp_en, buzzer, led, bad_digit
  );
endinterface

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - digit latch, timed buzzer burst and sticky alarm LED
module alarm_sequencer #(
  parameter int THRESH       = 7,
  parameter int BEEP_ON_CYC  = 6000000,
  parameter int BEEP_OFF_CYC = 6000000,
  parameter int NUM_BEEPS    = 3,
  parameter int IDLE_TO_CYC  = 120000000
) (
  input  logic             clk,
  input  logic             rst,
  alarm_sequencer_if.slave bus
);
  localparam int PH_MAX = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int CW     = $clog2(NUM_BEEPS + 1);
  localparam int IW     = $clog2(IDLE_TO_CYC + 1);

  localparam logic [PW-1:0] ON_LAST   = PW'(BEEP_ON_CYC - 1);
  localparam logic [PW-1:0] OFF_LAST  = PW'(BEEP_OFF_CYC - 1);
  localparam logic [CW-1:0] BEEPS     = CW'(NUM_BEEPS);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TO_CYC - 1);
  localparam logic [3:0]    THR       = 4'(THRESH);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_BEEP_ON, S_BEEP_OFF} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_ph, w_ph_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_idle, w_idle_nxt;
  logic [3:0]    r_disp_digit, w_disp_digit_nxt;
  logic          r_disp_en, w_disp_en_nxt;
  logic          r_buzzer, w_buzzer_nxt;
  logic          r_led, w_led_nxt;
  logic          r_bad, w_bad_nxt;

  logic w_valid, w_hi, w_beeping, w_tmo;

  assign w_valid   = bus.data_valid && (bus.digit <= 4'd9);
  assign w_hi      = (bus.digit >= THR);
  assign w_beeping = (r_state == S_BEEP_ON) || (r_state == S_BEEP_OFF);
  assign w_tmo     = !bus.data_valid && (r_state != S_IDLE) && (r_idle == IDLE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ph         <= '0;
      r_cnt        <= '0;
      r_idle       <= '0;
      r_disp_digit <= '0;
      r_disp_en    <= 1'b0;
      r_buzzer     <= 1'b0;
      r_led        <= 1'b0;
      r_bad        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ph         <= w_ph_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idle       <= w_idle_nxt;
      r_disp_digit <= w_disp_digit_nxt;
      r_disp_en    <= w_disp_en_nxt;
      r_buzzer     <= w_buzzer_nxt;
      r_led        <= w_led_nxt;
      r_bad        <= w_bad_nxt;
    end
  end

  // Later assignments take priority: phase progress < ack < idle timeout < valid digit.
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = r_ph;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;
    case (r_state)
      S_BEEP_ON: begin
        if (r_ph == ON_LAST) begin
          w_state_nxt = S_BEEP_OFF;
          w_ph_nxt    = '0;
          w_cnt_nxt   = r_cnt + CW'(1);
        end else begin
          w_ph_nxt = r_ph + PW'(1);
        end
      end
      S_BEEP_OFF: begin
        if (r_ph == OFF_LAST) begin
          w_ph_nxt = '0;
          if (r_cnt < BEEPS) begin
            w_state_nxt = S_BEEP_ON;
          end else begin
            w_state_nxt = S_SHOW;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_ph_nxt = r_ph + PW'(1);
        end
      end
      default: ;
    endcase
    if ((r_state != S_IDLE) && !bus.data_valid) w_idle_nxt = r_idle + IW'(1);
    if (bus.ack && w_beeping) begin
      w_state_nxt = S_SHOW;
      w_ph_nxt    = '0;
      w_cnt_nxt   = '0;
    end
    if (w_tmo) begin
      w_state_nxt = S_IDLE;
      w_ph_nxt    = '0;
      w_cnt_nxt   = '0;
      w_idle_nxt  = '0;
    end
    if (w_valid) begin
      w_state_nxt = w_hi ? S_BEEP_ON : S_SHOW;
      w_ph_nxt    = '0;
      w_cnt_nxt   = '0;
      w_idle_nxt  = '0;
    end
  end

  always_comb begin
    w_buzzer_nxt     = (w_state_nxt == S_BEEP_ON);
    w_disp_en_nxt    = (w_state_nxt != S_IDLE);
    w_disp_digit_nxt = w_valid ? bus.digit : r_disp_digit;
    w_bad_nxt        = bus.data_valid && (bus.digit > 4'd9);
    w_led_nxt        = r_led;
    if (bus.ack) w_led_nxt = 1'b0;
    if (w_valid && w_hi) w_led_nxt = 1'b1;
  end

  assign bus.disp_digit = r_disp_digit;
  assign bus.disp_en    = r_disp_en;
  assign bus.buzzer     = r_buzzer;
  assign bus.led        = r_led;
  assign bus.bad_digit  = r_bad;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb/tb_alarm_sequencer.sv - scoreboard bench for alarm_sequencer
module tb_alarm_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alarm_sequencer_if bus();

  alarm_sequencer #(
    .THRESH(7), .BEEP_ON_CYC(4), .BEEP_OFF_CYC(3), .NUM_BEEPS(2), .IDLE_TO_CYC(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic dv; logic [3:0] dg; logic ak;} stim_t;
  typedef struct packed {logic [3:0] dd; logic en; logic bz; logic led; logic bad;} exp_t;

  stim_t sq[$];
  exp_t  eq[$];
  stim_t s;
  exp_t  e;
  exp_t  got;

  task automatic push(input logic dv, input logic [3:0] dg, input logic ak,
                      input logic [3:0] dd, input logic en, input logic bz,
                      input logic led, input logic bad);
    sq.push_back({dv, dg, ak});
    eq.push_back({dd, en, bz, led, bad});
  endtask

  task automatic pi(input logic [3:0] dd, input logic en, input logic bz, input logic led);
    push(1'b0, 4'd0, 1'b0, dd, en, bz, led, 1'b0);
  endtask

  task automatic do_reset();
    bus.data_valid = 1'b0;
    bus.digit      = 4'd0;
    bus.ack        = 1'b0;
    rst            = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    int cyc = 0;
    do_reset();
    checks++;
    got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
    if (got !== 8'b0) begin
      errors++;
      $display("FAIL reset_init got=%b exp=%b", got, 8'b0);
    end
    pi(4'd0, 1'b0, 1'b0, 1'b0);
    pi(4'd0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 4'd8, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    pi(4'd8, 1'b1, 1'b1, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_reset cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
    if (got !== 8'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", got, 8'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    pi(4'd0, 1'b0, 1'b0, 1'b0);
    pi(4'd0, 1'b0, 1'b0, 1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_reset_release cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_show_timeout();
    int cyc = 0;
    do_reset();
    push(1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) pi(4'd3, 1'b1, 1'b0, 1'b0);
    pi(4'd3, 1'b0, 1'b0, 1'b0);
    pi(4'd3, 1'b0, 1'b0, 1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_show_timeout cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_burst();
    int cyc = 0;
    do_reset();
    push(1'b1, 4'd8, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pi(4'd8, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) pi(4'd8, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pi(4'd8, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) pi(4'd8, 1'b1, 1'b0, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_burst cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_ack();
    int cyc = 0;
    do_reset();
    push(1'b1, 4'd9, 1'b0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    pi(4'd9, 1'b1, 1'b1, 1'b1);
    push(1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pi(4'd9, 1'b1, 1'b0, 1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_ack cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_bad_digit();
    int cyc = 0;
    do_reset();
    push(1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) pi(4'd5, 1'b1, 1'b0, 1'b0);
    push(1'b1, 4'd12, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 11; i < 41; i++) pi(4'd5, 1'b1, 1'b0, 1'b0);
    pi(4'd5, 1'b0, 1'b0, 1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_bad_digit cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_restart();
    int cyc = 0;
    do_reset();
    push(1'b1, 4'd8, 1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pi(4'd8, 1'b1, 1'b1, 1'b1);
    pi(4'd8, 1'b1, 1'b0, 1'b1);
    push(1'b1, 4'd7, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pi(4'd7, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) pi(4'd7, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pi(4'd7, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) pi(4'd7, 1'b1, 1'b0, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_restart cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    do_reset();
    push(1'b1, 4'd3,  1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 4'd8,  1'b0, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1'b1, 4'd6,  1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b0, 4'd0,  1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 4'd7,  1'b0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1'b1, 4'd10, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1);
    push(1'b1, 4'd2,  1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 4'd15, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    pi(4'd2, 1'b1, 1'b0, 1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      bus.data_valid = s.dv; bus.digit = s.dg; bus.ack = s.ak;
      @(posedge clk); #1;
      bus.data_valid = 1'b0; bus.ack = 1'b0;
      e = eq.pop_front();
      checks++;
      got = {bus.disp_digit, bus.disp_en, bus.buzzer, bus.led, bus.bad_digit};
      if (got !== e) begin
        errors++;
        $display("FAIL test_back_to_back cyc=%0d got=%b exp=%b", cyc, got, e);
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_show_timeout();
    test_burst();
    test_ack();
    test_bad_digit();
    test_restart();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
